// File: rtl/pipearch_common.sv
// Shared types for the strided BRAM read engine: FSM state and latched config payload.
package pipearch_common;

  localparam int unsigned RBS_ADDR_W = 16;
  localparam int unsigned RBS_LEN_W  = 16;
  localparam int unsigned RBS_REP_W  = 8;

  typedef enum logic [1:0] {
    RBS_IDLE  = 2'd0,
    RBS_ISSUE = 2'd1,
    RBS_DRAIN = 2'd2
  } t_rbs_state;

  typedef struct packed {
    logic [RBS_ADDR_W-1:0] offset;
    logic [RBS_LEN_W-1:0]  length;
    logic [RBS_ADDR_W-1:0] stride;
    logic [RBS_REP_W-1:0]  repeat_cnt;
  } t_rbs_config;

endpackage

// File: rtl/read_bram_strided_read_addr_gen.sv
// Strided, multi-pass address sequencer; flags the last line of each pass and of the whole op.
module read_addr_gen
  import pipearch_common::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  t_rbs_config           cfg,
  input  logic                  advance,
  output logic [RBS_ADDR_W-1:0] addr,
  output logic                  pass_last_c,
  output logic                  op_last_c
);

  t_rbs_config           cfg_q,  cfg_d;
  logic [RBS_ADDR_W-1:0] addr_q, addr_d;
  logic [RBS_LEN_W-1:0]  idx_q,  idx_d;
  logic [RBS_REP_W-1:0]  pass_q, pass_d;

  always_comb begin
    cfg_d       = cfg_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    pass_last_c = (idx_q == cfg_q.length - RBS_LEN_W'(1));
    op_last_c   = pass_last_c && (pass_q == cfg_q.repeat_cnt);
    if (load) begin
      cfg_d  = cfg;
      addr_d = cfg.offset;
      idx_d  = '0;
      pass_d = '0;
    end else if (advance) begin
      // Pass boundary reloads the offset so the next pass starts without a bubble
      if (pass_last_c) begin
        idx_d  = '0;
        addr_d = cfg_q.offset;
        pass_d = pass_q + RBS_REP_W'(1);
      end else begin
        idx_d  = idx_q + RBS_LEN_W'(1);
        addr_d = addr_q + cfg_q.stride;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q  <= '0;
      addr_q <= '0;
      idx_q  <= '0;
      pass_q <= '0;
    end else begin
      cfg_q  <= cfg_d;
      addr_q <= addr_d;
      idx_q  <= idx_d;
      pass_q <= pass_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/read_bram_strided.sv
// BRAM read engine: issues a strided, repeated read sequence and forwards returns with per-pass last tags.
module read_bram_strided
  import pipearch_common::*;
#(
  parameter int unsigned ADDR_WIDTH   = RBS_ADDR_W,
  parameter int unsigned LEN_WIDTH    = RBS_LEN_W,
  parameter int unsigned REP_WIDTH    = RBS_REP_W,
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_start,
  input  logic [ADDR_WIDTH-1:0] cfg_offset,
  input  logic [LEN_WIDTH-1:0]  cfg_length,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  input  logic [REP_WIDTH-1:0]  cfg_repeat,
  output logic                  op_busy,
  output logic                  op_done,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_rvalid,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic                  out_last,
  input  logic                  out_almostfull
);

  localparam int unsigned IF_W = $clog2(MAX_INFLIGHT + 1);

  t_rbs_state            state_q,      state_d;
  logic [IF_W-1:0]       inflight_q,   inflight_d;
  logic                  ret_done_q,   ret_done_d;
  logic                  mem_re_q,     mem_re_d;
  logic [ADDR_WIDTH-1:0] mem_raddr_q,  mem_raddr_d;
  logic                  out_rvalid_q, out_rvalid_d;
  logic [DATA_WIDTH-1:0] out_rdata_q,  out_rdata_d;
  logic                  out_last_q,   out_last_d;
  logic                  op_busy_q,    op_busy_d;
  logic                  op_done_q,    op_done_d;

  logic                  load_c, issue_c, fwd_c;
  t_rbs_config           cfg_in_c;
  logic [RBS_ADDR_W-1:0] iss_addr;
  logic                  iss_pass_last_c, iss_op_last_c;
  logic [RBS_ADDR_W-1:0] ret_addr_unused;
  logic                  ret_pass_last_c, ret_op_last_c;

  assign cfg_in_c = '{offset: cfg_offset, length: cfg_length,
                      stride: cfg_stride, repeat_cnt: cfg_repeat};

  read_addr_gen u_issue_gen (
    .clk         (clk),
    .reset       (reset),
    .load        (load_c),
    .cfg         (cfg_in_c),
    .advance     (issue_c),
    .addr        (iss_addr),
    .pass_last_c (iss_pass_last_c),
    .op_last_c   (iss_op_last_c)
  );

  // Return-side tracker: same sequencer, stepped by forwarded beats
  read_addr_gen u_return_gen (
    .clk         (clk),
    .reset       (reset),
    .load        (load_c),
    .cfg         (cfg_in_c),
    .advance     (fwd_c),
    .addr        (ret_addr_unused),
    .pass_last_c (ret_pass_last_c),
    .op_last_c   (ret_op_last_c)
  );

  always_comb begin
    state_d      = state_q;
    inflight_d   = inflight_q;
    ret_done_d   = ret_done_q;
    mem_re_d     = 1'b0;
    mem_raddr_d  = mem_raddr_q;
    out_rvalid_d = 1'b0;
    out_rdata_d  = out_rdata_q;
    out_last_d   = 1'b0;
    op_done_d    = 1'b0;
    load_c       = 1'b0;
    issue_c      = 1'b0;
    fwd_c        = mem_rvalid && (state_q != RBS_IDLE);

    unique case (state_q)
      RBS_IDLE: begin
        if (op_start) begin
          if (cfg_length == '0) begin
            op_done_d = 1'b1;
          end else begin
            load_c     = 1'b1;
            ret_done_d = 1'b0;
            inflight_d = '0;
            state_d    = RBS_ISSUE;
          end
        end
      end
      RBS_ISSUE: begin
        issue_c = !out_almostfull && (inflight_q < IF_W'(MAX_INFLIGHT));
        if (issue_c && iss_op_last_c) state_d = RBS_DRAIN;
      end
      RBS_DRAIN: begin
        if ((inflight_q == '0) && ret_done_q) begin
          op_done_d = 1'b1;
          state_d   = RBS_IDLE;
        end
      end
      default: state_d = RBS_IDLE;
    endcase

    if (issue_c) begin
      mem_re_d    = 1'b1;
      mem_raddr_d = ADDR_WIDTH'(iss_addr);
    end

    if (fwd_c) begin
      out_rvalid_d = 1'b1;
      out_rdata_d  = mem_rdata;
      out_last_d   = ret_pass_last_c;
      if (ret_op_last_c) ret_done_d = 1'b1;
    end

    unique case ({issue_c, fwd_c})
      2'b10:   inflight_d = inflight_q + IF_W'(1);
      2'b01:   inflight_d = inflight_q - IF_W'(1);
      default: ;
    endcase

    op_busy_d = (state_d != RBS_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RBS_IDLE;
      inflight_q   <= '0;
      ret_done_q   <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_raddr_q  <= '0;
      out_rvalid_q <= 1'b0;
      out_rdata_q  <= '0;
      out_last_q   <= 1'b0;
      op_busy_q    <= 1'b0;
      op_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      ret_done_q   <= ret_done_d;
      mem_re_q     <= mem_re_d;
      mem_raddr_q  <= mem_raddr_d;
      out_rvalid_q <= out_rvalid_d;
      out_rdata_q  <= out_rdata_d;
      out_last_q   <= out_last_d;
      op_busy_q    <= op_busy_d;
      op_done_q    <= op_done_d;
    end
  end

  assign mem_re     = mem_re_q;
  assign mem_raddr  = mem_raddr_q;
  assign out_rvalid = out_rvalid_q;
  assign out_rdata  = out_rdata_q;
  assign out_last   = out_last_q;
  assign op_busy    = op_busy_q;
  assign op_done    = op_done_q;

endmodule

// File: tb/tb_read_bram_strided.sv
// Directed bench for read_bram_strided with a 1- or 2-cycle BRAM model and backpressure pattern.
module tb_read_bram_strided;

  typedef logic [15:0] addr_q_t[$];

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         op_start = 1'b0;
  logic [15:0]  cfg_offset = '0;
  logic [15:0]  cfg_length = '0;
  logic [15:0]  cfg_stride = '0;
  logic [7:0]   cfg_repeat = '0;
  logic         op_busy, op_done, mem_re, mem_rvalid, out_rvalid, out_last;
  logic         out_almostfull = 1'b0;
  logic [15:0]  mem_raddr;
  logic [511:0] mem_rdata, out_rdata;

  read_bram_strided dut (
    .clk(clk), .reset(reset), .op_start(op_start),
    .cfg_offset(cfg_offset), .cfg_length(cfg_length),
    .cfg_stride(cfg_stride), .cfg_repeat(cfg_repeat),
    .op_busy(op_busy), .op_done(op_done),
    .mem_re(mem_re), .mem_raddr(mem_raddr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_rvalid(out_rvalid), .out_rdata(out_rdata), .out_last(out_last),
    .out_almostfull(out_almostfull)
  );

  always #5 clk = ~clk;

  // BRAM model: data is the address replicated across the line
  int          lat = 1;
  logic        p1_v = 1'b0, p2_v = 1'b0;
  logic [15:0] p1_a = '0, p2_a = '0;
  always @(posedge clk) begin
    p1_v <= mem_re;
    p1_a <= mem_raddr;
    p2_v <= p1_v;
    p2_a <= p1_a;
  end
  assign mem_rvalid = (lat == 2) ? p2_v : p1_v;
  assign mem_rdata  = {32{(lat == 2) ? p2_a : p1_a}};

  int n_checks = 0, n_pass = 0;
  int cyc = 0, start_cyc = 0, done_cnt = 0, done_cyc = 0;
  int af_viol = 0, outstanding = 0, max_out = 0;
  bit busy_seen = 0, af_toggle = 0, af_prev = 0;
  logic [15:0] iss_addr[$];
  int          iss_cyc[$];
  logic [63:0] beat_data[$];
  logic        beat_last[$];
  int          beat_cyc[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // One cycle: sample DUT at the falling edge, then update backpressure
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mem_re) begin
      iss_addr.push_back(mem_raddr);
      iss_cyc.push_back(cyc);
      if (af_prev) af_viol++;
    end
    if (out_rvalid) begin
      beat_data.push_back(out_rdata[63:0]);
      beat_last.push_back(out_last);
      beat_cyc.push_back(cyc);
    end
    if (op_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (op_busy) busy_seen = 1;
    outstanding += int'(mem_re) - int'(mem_rvalid);
    if (outstanding > max_out) max_out = outstanding;
    out_almostfull = af_toggle ? (((cyc / 3) % 2) == 1) : 1'b0;
    af_prev = out_almostfull;
  endtask

  task automatic clear_mon();
    iss_addr.delete(); iss_cyc.delete();
    beat_data.delete(); beat_last.delete(); beat_cyc.delete();
    done_cnt = 0; done_cyc = 0; busy_seen = 0;
    af_viol = 0; outstanding = 0; max_out = 0;
  endtask

  task automatic start_op(input logic [15:0] off, input logic [15:0] len,
                          input logic [15:0] str, input logic [7:0] rep);
    cfg_offset = off; cfg_length = len; cfg_stride = str; cfg_repeat = rep;
    op_start = 1'b1;
    start_cyc = cyc;
    tick();
    op_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 400 && done_cnt == 0; i++) tick();
    if (done_cnt == 0) check({nm, " timeout"}, 64'(done_cnt), 64'(1));
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic verify(input string nm, input addr_q_t ea, input int len, input bit dense);
    int n;
    n = ea.size();
    check({nm, " n_reads"}, 64'(iss_addr.size()), 64'(n));
    check({nm, " n_beats"}, 64'(beat_data.size()), 64'(n));
    for (int i = 0; i < n && i < iss_addr.size(); i++)
      check($sformatf("%s raddr%0d", nm, i), 64'(iss_addr[i]), 64'(ea[i]));
    for (int i = 0; i < n && i < beat_data.size(); i++) begin
      check($sformatf("%s data%0d", nm, i), beat_data[i], {4{ea[i]}});
      check($sformatf("%s last%0d", nm, i), 64'(beat_last[i]), 64'((i % len) == len - 1));
    end
    if (dense)
      for (int i = 1; i < iss_cyc.size(); i++)
        check($sformatf("%s gap%0d", nm, i), 64'(iss_cyc[i] - iss_cyc[i-1]), 64'(1));
    check({nm, " done_cnt"}, 64'(done_cnt), 64'(1));
    if (beat_cyc.size() > 0)
      check({nm, " done_lag"}, 64'(done_cyc - beat_cyc[beat_cyc.size()-1]), 64'(1));
    check({nm, " idle_after"}, 64'(op_busy), 64'(0));
  endtask

  initial begin
    addr_q_t e;
    int nb;

    // Reset values
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rst mem_re", 64'(mem_re), 64'(0));
    check("rst out_rvalid", 64'(out_rvalid), 64'(0));
    check("rst out_last", 64'(out_last), 64'(0));
    check("rst op_busy", 64'(op_busy), 64'(0));
    check("rst op_done", 64'(op_done), 64'(0));
    check("rst mem_raddr", 64'(mem_raddr), 64'(0));
    check("rst out_rdata", out_rdata[63:0], 64'(0));
    reset = 1'b0;
    tick();

    // Contiguous single pass
    clear_mon(); lat = 1;
    start_op(16'h0010, 16'd4, 16'd1, 8'd0);
    wait_done("t1");
    e = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    verify("t1", e, 4, 1);
    if (iss_cyc.size() > 0) check("t1 start_lat", 64'(iss_cyc[0] - start_cyc), 64'(2));
    check("t1 busy_seen", 64'(busy_seen), 64'(1));

    // Wrapping stride with one repeat
    clear_mon();
    start_op(16'hFFFE, 16'd4, 16'd3, 8'd1);
    wait_done("t2");
    e = '{16'hFFFE, 16'h0001, 16'h0004, 16'h0007, 16'hFFFE, 16'h0001, 16'h0004, 16'h0007};
    verify("t2", e, 4, 1);

    // Zero length
    clear_mon();
    start_op(16'h0030, 16'd0, 16'd1, 8'd0);
    for (int i = 0; i < 5; i++) tick();
    check("t3 n_reads", 64'(iss_addr.size()), 64'(0));
    check("t3 done_cnt", 64'(done_cnt), 64'(1));
    check("t3 done_lat", 64'(done_cyc - start_cyc), 64'(1));
    check("t3 busy_seen", 64'(busy_seen), 64'(0));

    // Backpressure toggling every 3 cycles, 2-cycle BRAM latency
    clear_mon(); lat = 2; af_toggle = 1;
    start_op(16'h0200, 16'd16, 16'd1, 8'd0);
    wait_done("t4");
    af_toggle = 0;
    e = {};
    for (int i = 0; i < 16; i++) e.push_back(16'h0200 + 16'(i));
    verify("t4", e, 16, 0);
    check("t4 af_viol", 64'(af_viol), 64'(0));
    check("t4 max_inflight_gt8", 64'(max_out > 8), 64'(0));

    // Reset with reads in flight
    clear_mon(); lat = 2;
    start_op(16'h0100, 16'd8, 16'd1, 8'd0);
    for (int i = 0; i < 20 && iss_addr.size() < 2; i++) tick();
    check("t5 reads_before_rst", 64'(iss_addr.size()), 64'(2));
    nb = beat_data.size();
    reset = 1'b1;
    tick();
    check("t5 mem_re", 64'(mem_re), 64'(0));
    check("t5 op_busy", 64'(op_busy), 64'(0));
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t5 stale_beats", 64'(beat_data.size() - nb), 64'(0));
    check("t5 stale_done", 64'(done_cnt), 64'(0));
    clear_mon(); lat = 1;
    start_op(16'h0020, 16'd4, 16'd1, 8'd0);
    wait_done("t5b");
    e = '{16'h0020, 16'h0021, 16'h0022, 16'h0023};
    verify("t5b", e, 4, 1);

    // Start strobe during ISSUE must be ignored
    clear_mon(); lat = 1; af_toggle = 1;
    start_op(16'h0040, 16'd6, 16'd2, 8'd0);
    tick();
    cfg_offset = 16'h0900; cfg_length = 16'd1; cfg_stride = 16'd7; cfg_repeat = 8'd3;
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    wait_done("t6");
    af_toggle = 0;
    e = '{16'h0040, 16'h0042, 16'h0044, 16'h0046, 16'h0048, 16'h004A};
    verify("t6", e, 6, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
